ologic_align_gen: RTL and testbench
===================================

# ologic_align_gen

Parametrised multi-channel alignment-pattern generator for the output-logic serialiser domain, running on `gsclk_ol`. After reset, or after a re-align request, it waits a programmable startup delay. It then drives a phase-coherent square-wave align pattern on every enabled channel, and flags `align_done` once a programmable number of full periods has elapsed. With NUM_CH=1, RATIO=2, START_DLY=0 and all channels enabled, `align_ol` toggles on every edge after reset is released, which is the existing single-channel align behaviour.

## Interface
Parameters:
- NUM_CH, 4: number of align output channels (≥1).
- RATIO, 2: pattern period in `gsclk_ol` cycles. Must be even and ≥2. Output is high for RATIO/2 cycles, then low for RATIO/2 cycles.
- START_DLY, 0: cycles held low after reset or re-align before the pattern starts (≥0).
- LOCK_PER, 4: number of complete pattern periods before `align_done` asserts (≥1).

Ports:
- gsclk_ol, in, 1: the single clock.
- rst, in, 1: reset, synchronous, active-high.
- realign_req, in, 1: restart request, sampled every edge.
- ch_en, in, NUM_CH: per-channel enable.
- align_ol, out, NUM_CH: align pattern, one bit per channel, registered.
- align_done, out, 1: lock reached, registered.
- align_busy, out, 1: high in WAIT or RUN until lock, registered.

## Operation
- The FSM has three states: WAIT (startup delay), RUN (pattern before lock) and LOCK (pattern continues, done asserted).
- Reset values:
  - state = WAIT, all counters = 0.
  - align_ol = 0, align_done = 0, align_busy = 1.
  - Every channel is inactive.
- WAIT:
  - The delay counter counts START_DLY cycles, then the FSM moves to RUN.
  - If START_DLY = 0, WAIT lasts zero cycles.
- RUN and LOCK:
  - A phase counter runs 0..RATIO-1 and wraps.
  - Active channels drive 1 while phase < RATIO/2, otherwise 0.
  - A period counter counts phase wraps. When the LOCK_PER-th wrap completes, the FSM moves to LOCK. The period counter then saturates and never wraps.
- Channel activity:
  - An inactive channel whose ch_en is 1 becomes active only on the edge where phase returns to 0, i.e. the first high cycle of a period. This keeps all channels phase-coherent.
  - ch_en = 0 deactivates the channel and drives its align_ol bit to 0 on the same edge, in any state.
  - align_done is independent of channel enables.
- realign_req = 1 sampled on an edge:
  - All align_ol go to 0, align_done goes to 0 and align_busy goes to 1.
  - Counters clear, the FSM enters WAIT, and all channels become inactive.
  - While realign_req is held high the block stays in this state, so align_ol stays 0.
- Priority: rst > realign_req > normal operation.
- Widths:
  - Delay counter: $clog2(START_DLY+1) bits, minimum 1.
  - Phase counter: $clog2(RATIO) bits.
  - Period counter: $clog2(LOCK_PER+1) bits.
  - Invalid parameter values fail at elaboration via a generate-time check.

## Timing
- Edge 1 is the first edge on which rst (or realign_req) is sampled low.
- Edges 1..START_DLY: align_ol = 0.
- From edge START_DLY+1, for each enabled channel: RATIO/2 edges of 1, then RATIO/2 edges of 0, repeating.
- A channel enabled at time 0 is active from edge START_DLY+1.
- align_done and align_busy:
  - align_done rises on edge START_DLY + LOCK_PER·RATIO.
  - align_busy falls on that same edge.
  - Both then hold until rst or realign_req.
- ch_en rising mid-period: the channel's first 1 appears on the next phase-0 edge, never mid-period.
- ch_en falling: the bit reads 0 on the edge that samples ch_en low. That is one cycle of latency, as for every output.
- rst or realign_req in any state, including mid-period or during LOCK: all outputs take their reset values on that edge.

## Structure
- Package `ologic_align_pkg` holds:
  - the state enum (WAIT/RUN/LOCK);
  - the counter-width helper function;
  - the parameter-legality check function.
- Sub-module `ologic_align_phase` contains the phase counter and period counter. It outputs `phase_zero`, `phase_hi` and `lock_hit`.
- The top level contains the FSM, per-channel activity registers and output registers.

## Test plan
1. NUM_CH=1, RATIO=2, START_DLY=0, LOCK_PER=4; release rst → align_ol = 1,0,1,0,… from edge 1; align_done = 1 at edge 8.
2. RATIO=4, START_DLY=3; release rst → align_ol = 0,0,0,1,1,0,0,1,1,…; align_done = 1 at edge 3+16 = 19.
3. RATIO=4, ch_en[2] raised at edge 6 (phase 2) → align_ol[2] first goes 1 at edge 8, in phase with ch0. Drop ch_en[2] at edge 13 → align_ol[2] = 0 at edge 13, while ch0 is unaffected.
4. Pulse realign_req for 1 cycle during LOCK → all outputs = 0, align_done = 0 on that edge. The pattern restarts after START_DLY, and done re-asserts after START_DLY + LOCK_PER·RATIO further edges.
5. realign_req held high for 10 edges → align_ol stays 0 throughout. Asserting rst together with realign_req gives reset behaviour, identical to test 1.
6. Random ch_en toggling over 1000 cycles with NUM_CH=4 → every active channel matches a reference phase model, and no channel ever shows a 1 outside phase < RATIO/2.

Source files
------------

// File: rtl/ologic_align_pkg.sv
// ---------------------------------------------------------------------------
// ologic_align_pkg
// Shared types and elaboration helpers for the output-logic align pattern
// generator: FSM state encoding, counter width sizing and parameter legality.
// ---------------------------------------------------------------------------
package ologic_align_pkg;

    // WAIT: startup delay, RUN: pattern before lock, LOCK: pattern with done
    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOCK = 2'd2
    } align_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Legal generator configuration
    function automatic bit params_legal(
        input int num_ch,
        input int ratio,
        input int start_dly,
        input int lock_per
    );
        return (num_ch >= 1) && (ratio >= 2) && ((ratio % 2) == 0) &&
               (start_dly >= 0) && (lock_per >= 1);
    endfunction

endpackage : ologic_align_pkg

// File: rtl/ologic_align_phase.sv
// ---------------------------------------------------------------------------
// ologic_align_phase
// Phase counter (0..RATIO-1, wrapping) and saturating period counter for the
// align pattern. Both counters only move on pattern edges (advance = 1).
//
// Ports:
//   clk        - pattern clock
//   rst        - synchronous active-high reset
//   clr        - synchronous clear (re-align), same effect as rst
//   advance    - this edge emits a pattern cycle
//   phase_zero - current phase is the first high cycle of a period
//   phase_hi   - current phase lies in the high half of the period
//   lock_hit   - current cycle completes the LOCK_PER-th period
// ---------------------------------------------------------------------------
module ologic_align_phase
    import ologic_align_pkg::*;
#(
    parameter int RATIO    = 2,
    parameter int LOCK_PER = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic advance,
    output logic phase_zero,
    output logic phase_hi,
    output logic lock_hit
);

    localparam int unsigned PH_W  = cnt_width(RATIO);
    localparam int unsigned PER_W = cnt_width(LOCK_PER + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(RATIO - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(RATIO / 2);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(LOCK_PER - 1);
    localparam logic [PER_W-1:0] PER_SAT  = PER_W'(LOCK_PER);

    logic [PH_W-1:0]  phase;
    logic [PER_W-1:0] periods;
    logic             wrap;

    // phase holds the position presented on the next pattern edge
    assign wrap = (phase == PH_LAST);

    // Phase wraps; period count saturates once lock is reached
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase   <= '0;
            periods <= '0;
        end else if (advance) begin
            phase <= wrap ? '0 : phase + PH_W'(1);
            if (wrap && (periods != PER_SAT)) begin
                periods <= periods + PER_W'(1);
            end
        end
    end

    assign phase_zero = (phase == '0);
    assign phase_hi   = (phase < PH_HALF);
    assign lock_hit   = wrap && (periods == PER_LAST);

endmodule : ologic_align_phase

// File: rtl/ologic_align_gen.sv
// ---------------------------------------------------------------------------
// ologic_align_gen
// Multi-channel phase-coherent square-wave align pattern generator for the
// serialiser output domain. After reset or a re-align request it holds all
// outputs low for START_DLY cycles, then drives RATIO/2 high and RATIO/2 low
// cycles per period on every active channel, and flags align_done after
// LOCK_PER complete periods.
//
// Ports:
//   gsclk_ol    - clock
//   rst         - synchronous active-high reset
//   realign_req - restart request, sampled every edge
//   ch_en       - per-channel enable [NUM_CH]
//   align_ol    - registered align pattern [NUM_CH]
//   align_done  - registered lock flag
//   align_busy  - registered, high while waiting or running before lock
// ---------------------------------------------------------------------------
module ologic_align_gen
    import ologic_align_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int RATIO     = 2,
    parameter int START_DLY = 0,
    parameter int LOCK_PER  = 4
) (
    input  logic              gsclk_ol,
    input  logic              rst,
    input  logic              realign_req,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] align_ol,
    output logic              align_done,
    output logic              align_busy
);

    // Reject illegal configurations at elaboration
    generate
        if (!params_legal(NUM_CH, RATIO, START_DLY, LOCK_PER)) begin : g_param_check
            $error("ologic_align_gen: illegal parameter set");
        end
    endgenerate

    localparam int unsigned DLY_W = cnt_width(START_DLY + 1);
    localparam logic [DLY_W-1:0] DLY_END = DLY_W'(START_DLY);

    align_state_e      state;
    logic [DLY_W-1:0]  dly_cnt;
    logic [NUM_CH-1:0] active;

    logic              run_c;
    logic              phase_zero;
    logic              phase_hi;
    logic              lock_hit;
    logic [NUM_CH-1:0] active_nxt_c;

    // Pattern edge: RUN/LOCK, or the WAIT edge where the delay has expired
    // (covers START_DLY = 0, where WAIT occupies no pattern-free edge)
    assign run_c = (state != ST_WAIT) || (dly_cnt == DLY_END);

    ologic_align_phase #(
        .RATIO    (RATIO),
        .LOCK_PER (LOCK_PER)
    ) u_phase (
        .clk        (gsclk_ol),
        .rst        (rst),
        .clr        (realign_req),
        .advance    (run_c),
        .phase_zero (phase_zero),
        .phase_hi   (phase_hi),
        .lock_hit   (lock_hit)
    );

    // Channels join only at phase 0 so all active channels stay coherent;
    // a low enable drops the channel immediately
    always_comb begin
        active_nxt_c = ch_en & (active | {NUM_CH{phase_zero}});
    end

    // FSM, delay counter, channel activity and registered outputs
    always_ff @(posedge gsclk_ol) begin
        if (rst || realign_req) begin
            state      <= ST_WAIT;
            dly_cnt    <= '0;
            active     <= '0;
            align_ol   <= '0;
            align_done <= 1'b0;
            align_busy <= 1'b1;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (dly_cnt == DLY_END) begin
                        state <= ST_RUN;
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end
                ST_RUN: begin
                    if (lock_hit) begin
                        state      <= ST_LOCK;
                        align_done <= 1'b1;
                        align_busy <= 1'b0;
                    end
                end
                ST_LOCK: begin
                    state <= ST_LOCK;
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase

            if (run_c) begin
                active   <= active_nxt_c;
                align_ol <= active_nxt_c & {NUM_CH{phase_hi}};
            end else begin
                active   <= '0;
                align_ol <= '0;
            end
        end
    end

endmodule : ologic_align_gen

// File: tb/tb_ologic_align_gen.sv
// ---------------------------------------------------------------------------
// tb_ologic_align_gen
// Directed and randomized bench for ologic_align_gen. Two instances share
// rst/realign_req: a 4-channel RATIO=4 START_DLY=3 unit and a 1-channel
// RATIO=2 START_DLY=0 unit. Expected outputs come from an edge-count model:
// k = edges since the last reset/re-align, pattern position p = k-START_DLY-1.
// ---------------------------------------------------------------------------
module tb_ologic_align_gen;

    localparam int NCH = 4;
    localparam int R   = 4;
    localparam int SD  = 3;
    localparam int LP  = 4;
    localparam int R1  = 2;
    localparam int SD1 = 0;
    localparam int LP1 = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           realign_req;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] ol;
    logic           done;
    logic           busy;
    logic [0:0]     en1;
    logic [0:0]     ol1;
    logic           done1;
    logic           busy1;

    int             checks   = 0;
    int             failures = 0;
    int             k        = 0;
    logic [NCH-1:0] act      = '0;
    logic [NCH-1:0] m_ol     = '0;
    logic           act1     = 1'b0;
    logic           m_ol1    = 1'b0;
    logic           m_done   = 1'b0;
    logic           m_done1  = 1'b0;

    always #5 clk = ~clk;

    ologic_align_gen #(
        .NUM_CH(NCH), .RATIO(R), .START_DLY(SD), .LOCK_PER(LP)
    ) dut (
        .gsclk_ol    (clk),
        .rst         (rst),
        .realign_req (realign_req),
        .ch_en       (ch_en),
        .align_ol    (ol),
        .align_done  (done),
        .align_busy  (busy)
    );

    ologic_align_gen #(
        .NUM_CH(1), .RATIO(R1), .START_DLY(SD1), .LOCK_PER(LP1)
    ) dut1 (
        .gsclk_ol    (clk),
        .rst         (rst),
        .realign_req (realign_req),
        .ch_en       (en1),
        .align_ol    (ol1),
        .align_done  (done1),
        .align_busy  (busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s @k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // One channel of the reference: joins at p%r==0, high for p%r < r/2
    task automatic model_ch(input int kk, input int sd, input int r, input logic en,
                            inout logic a, output logic o);
        int p;
        o = 1'b0;
        if (!en) begin
            a = 1'b0;
        end else if (kk > sd) begin
            p = (kk - sd - 1) % r;
            if (p == 0) a = 1'b1;
            o = a && (p < r / 2);
        end
    endtask

    // Drive one edge, advance the model, sample 1 time unit later
    task automatic step(input logic r_v, input logic rr_v, input logic [NCH-1:0] en_v);
        logic a;
        logic o;
        rst         = r_v;
        realign_req = rr_v;
        ch_en       = en_v;
        @(posedge clk);
        if (r_v || rr_v) begin
            k    = 0;
            act  = '0;
            act1 = 1'b0;
        end else begin
            k++;
        end
        for (int i = 0; i < NCH; i++) begin
            a = act[i];
            model_ch(k, SD, R, en_v[i], a, o);
            act[i]  = a;
            m_ol[i] = o;
        end
        model_ch(k, SD1, R1, en1[0], act1, m_ol1);
        m_done  = (k > 0) && (k >= SD + LP * R);
        m_done1 = (k > 0) && (k >= SD1 + LP1 * R1);
        #1;
        chk("ol",    32'(ol),    32'(m_ol));
        chk("done",  32'(done),  32'(m_done));
        chk("busy",  32'(busy),  32'(!m_done));
        chk("ol1",   32'(ol1),   32'(m_ol1));
        chk("done1", 32'(done1), 32'(m_done1));
        chk("busy1", 32'(busy1), 32'(!m_done1));
    endtask

    initial begin
        logic [NCH-1:0] en;
        logic           rr;
        rst         = 1'b1;
        realign_req = 1'b0;
        ch_en       = '1;
        en1         = 1'b1;

        // Reset state
        repeat (3) step(1'b1, 1'b0, '1);
        chk("rst_ol",   32'(ol),   32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Startup delay, pattern, mid-period enable and disable, lock
        for (int e = 1; e <= 24; e++) begin
            en = (e >= 6 && e <= 12) ? 4'b0111 : 4'b0011;
            step(1'b0, 1'b0, en);
            if (k == 3)  chk("dly_low",   32'(ol[0]), 32'd0);
            if (k == 4)  chk("first_hi",  32'(ol[0]), 32'd1);
            if (k == 6)  chk("low_half",  32'(ol[0]), 32'd0);
            if (k == 7)  chk("ch2_wait",  32'(ol[2]), 32'd0);
            if (k == 8)  chk("ch2_first", 32'(ol[2]), 32'd1);
            if (k == 8)  chk("ch0_coh",   32'(ol[0]), 32'd1);
            if (k == 13) chk("ch2_drop",  32'(ol[2]), 32'd0);
            if (k == 13) chk("ch0_keep",  32'(ol[0]), 32'd1);
            if (k == 18) chk("done_pre",  32'(done),  32'd0);
            if (k == 19) chk("done_rise", 32'(done),  32'd1);
            if (k == 19) chk("busy_fall", 32'(busy),  32'd0);
            if (k == 1)  chk("r2_e1",     32'(ol1),   32'd1);
            if (k == 2)  chk("r2_e2",     32'(ol1),   32'd0);
            if (k == 7)  chk("done1_pre", 32'(done1), 32'd0);
            if (k == 8)  chk("done1_rise",32'(done1), 32'd1);
        end

        // Single-cycle re-align during LOCK
        step(1'b0, 1'b1, 4'b0011);
        chk("rlg_ol",   32'(ol),   32'd0);
        chk("rlg_done", 32'(done), 32'd0);
        chk("rlg_busy", 32'(busy), 32'd1);
        for (int e = 1; e <= 22; e++) begin
            step(1'b0, 1'b0, 4'b1011);
            if (k == 4)  chk("rlg_restart", 32'(ol), 32'hb);
            if (k == 18) chk("rlg_pre",  32'(done), 32'd0);
            if (k == 19) chk("rlg_lock", 32'(done), 32'd1);
        end

        // Re-align held high
        repeat (10) begin
            step(1'b0, 1'b1, '1);
            chk("hold_ol",  32'(ol),  32'd0);
            chk("hold_ol1", 32'(ol1), 32'd0);
        end

        // Reset together with re-align, then single-channel toggle behaviour
        step(1'b1, 1'b1, '1);
        chk("rr_busy", 32'(busy1), 32'd1);
        chk("rr_ol",   32'(ol1),   32'd0);
        for (int e = 1; e <= 10; e++) begin
            step(1'b0, 1'b0, '1);
            chk("toggle1", 32'(ol1), 32'(k % 2));
        end

        // Random enables with rare re-align
        en = '1;
        repeat (1000) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(7) == 0) en[i] = ~en[i];
            end
            rr = ($urandom_range(255) == 0);
            step(1'b0, rr, en);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ologic_align_gen
